// File: rtl/red_pitaya_exp_debounce.sv
// red_pitaya_exp_debounce: per-bit synchroniser, debounce filter and edge detect for expansion pins
// Ports: clk_i/rstn_i clock and async active-low reset; exp_dat_i raw pins;
//   exp_dat_o filtered state; rise_o/fall_o one-cycle filtered edge pulses;
//   sys_* housekeeping-style bus slave (0x00 state, 0x04/0x08 W1C edge flags,
//   0x0C debounce length, 0x10 irq mask); irq_o level interrupt.
// Optional feature macro EXP_DEB_IRQ_EN adds the irq_mask register and irq_o.
module red_pitaya_exp_debounce #(
  parameter int          DW      = 8,
  parameter int          CW      = 16,
  parameter int unsigned DEB_DEF = 1250
) (
  input  logic          clk_i,
  input  logic          rstn_i,
  input  logic [DW-1:0] exp_dat_i,
  output logic [DW-1:0] exp_dat_o,
  output logic [DW-1:0] rise_o,
  output logic [DW-1:0] fall_o,
  input  logic [31:0]   sys_addr,
  input  logic [31:0]   sys_wdata,
  input  logic [3:0]    sys_sel,
  input  logic          sys_wen,
  input  logic          sys_ren,
  output logic [31:0]   sys_rdata,
  output logic          sys_err,
  output logic          sys_ack
`ifdef EXP_DEB_IRQ_EN
  ,
  output logic          irq_o
`endif
);
  logic [DW-1:0] r_s1, r_s2, r_filt, r_rise, r_fall, r_rise_f, r_fall_f;
  logic [CW-1:0] r_cnt [DW];
  logic [CW-1:0] r_deb_len, w_nm1;
  logic [19:0]   w_a;
  logic          w_deb_wr;
  logic [DW-1:0] w_clr_r, w_clr_f, w_mask;
  logic [31:0]   w_rdata;
  logic          w_unused;
  assign w_unused  = ^{sys_sel, sys_addr[31:20], sys_wdata[31:CW]};
  assign exp_dat_o = r_filt;
  assign rise_o    = r_rise;
  assign fall_o    = r_fall;
  assign sys_err   = 1'b0;
  always_comb begin
    w_a      = sys_addr[19:0];
    // a zero length behaves as one cycle
    w_nm1    = (r_deb_len == '0) ? '0 : r_deb_len - 1'b1;
    w_deb_wr = sys_wen && (w_a == 20'h0C);
    w_clr_r  = (sys_wen && (w_a == 20'h04)) ? sys_wdata[DW-1:0] : '0;
    w_clr_f  = (sys_wen && (w_a == 20'h08)) ? sys_wdata[DW-1:0] : '0;
    w_rdata  = (w_a == 20'h00) ? {{(32-DW){1'b0}}, r_filt}   :
               (w_a == 20'h04) ? {{(32-DW){1'b0}}, r_rise_f} :
               (w_a == 20'h08) ? {{(32-DW){1'b0}}, r_fall_f} :
               (w_a == 20'h0C) ? {{(32-CW){1'b0}}, r_deb_len} :
               (w_a == 20'h10) ? {{(32-DW){1'b0}}, w_mask}   : '0;
  end
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      r_s1      <= '0;
      r_s2      <= '0;
      r_filt    <= '0;
      r_rise    <= '0;
      r_fall    <= '0;
      r_rise_f  <= '0;
      r_fall_f  <= '0;
      r_deb_len <= CW'(DEB_DEF);
      sys_ack   <= 1'b0;
      sys_rdata <= '0;
      for (int i = 0; i < DW; i++) r_cnt[i] <= '0;
    end else begin
      r_s1      <= exp_dat_i;
      r_s2      <= r_s1;
      r_rise    <= '0;
      r_fall    <= '0;
      for (int i = 0; i < DW; i++)
        if (w_deb_wr || (r_s2[i] == r_filt[i])) r_cnt[i] <= '0;
        else if (r_cnt[i] != w_nm1) r_cnt[i] <= r_cnt[i] + 1'b1;
        else begin
          r_filt[i] <= r_s2[i];
          r_cnt[i]  <= '0;
          r_rise[i] <= r_s2[i];
          r_fall[i] <= ~r_s2[i];
        end
      // a new edge outranks a simultaneous W1C clear
      r_rise_f  <= (r_rise_f & ~w_clr_r) | r_rise;
      r_fall_f  <= (r_fall_f & ~w_clr_f) | r_fall;
      if (w_deb_wr) r_deb_len <= sys_wdata[CW-1:0];
      sys_ack   <= sys_wen | sys_ren;
      sys_rdata <= w_rdata;
    end
  end
`ifdef EXP_DEB_IRQ_EN
  logic [DW-1:0] r_irq_mask;
  logic          r_irq;
  assign w_mask = r_irq_mask;
  assign irq_o  = r_irq;
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      r_irq_mask <= '0;
      r_irq      <= 1'b0;
    end else begin
      if (sys_wen && (w_a == 20'h10)) r_irq_mask <= sys_wdata[DW-1:0];
      r_irq      <= |((r_rise_f | r_fall_f) & r_irq_mask);
    end
  end
`else
  assign w_mask = '0;
`endif
endmodule

// File: tb/tb_red_pitaya_exp_debounce.sv
// tb_red_pitaya_exp_debounce: directed self-checking bench for red_pitaya_exp_debounce
module tb_red_pitaya_exp_debounce;
  logic        clk = 1'b0, rstn_i = 1'b0;
  logic [7:0]  exp_dat_i = '0, exp_dat_o, rise_o, fall_o;
  logic [31:0] sys_addr = '0, sys_wdata = '0, sys_rdata;
  logic [3:0]  sys_sel = 4'hF;
  logic        sys_wen = 1'b0, sys_ren = 1'b0, sys_err, sys_ack;
  int          n_chk = 0, n_fail = 0;
`ifdef EXP_DEB_IRQ_EN
  logic        irq_o;
`endif
  always #5 clk = ~clk;
  red_pitaya_exp_debounce dut (
`ifdef EXP_DEB_IRQ_EN
    .irq_o(irq_o),
`endif
    .clk_i(clk), .rstn_i(rstn_i), .exp_dat_i(exp_dat_i), .exp_dat_o(exp_dat_o),
    .rise_o(rise_o), .fall_o(fall_o), .sys_addr(sys_addr), .sys_wdata(sys_wdata),
    .sys_sel(sys_sel), .sys_wen(sys_wen), .sys_ren(sys_ren), .sys_rdata(sys_rdata),
    .sys_err(sys_err), .sys_ack(sys_ack)
  );
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask
  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask
  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    @(negedge clk);
    sys_addr = a; sys_wdata = d; sys_wen = 1'b1;
    @(negedge clk);
    sys_wen = 1'b0;
  endtask
  task automatic rd(input string tag, input logic [31:0] a, input logic [31:0] exp);
    @(negedge clk);
    sys_addr = a; sys_ren = 1'b1;
    @(negedge clk);
    sys_ren = 1'b0;
    chk({tag, "_ack"}, {31'd0, sys_ack}, 32'd1);
    chk(tag, sys_rdata, exp);
  endtask
  initial begin
    logic [7:0] seen;
    bit ok;
    cyc(2);
    chk("rst_dat", {24'd0, exp_dat_o}, 0);
    chk("rst_edges", {16'd0, rise_o, fall_o}, 0);
    chk("rst_ack", {31'd0, sys_ack}, 0);
    chk("rst_rdata", sys_rdata, 0);
    rstn_i = 1'b1;
    rd("deb_def", 32'h0C, 32'd1250);
    wr(32'h0C, 32'd4);
    rd("deb_4", 32'h0C, 32'd4);
    exp_dat_i[3] = 1'b1;
    seen = '0;
    repeat (3) begin @(negedge clk); seen |= rise_o | fall_o | exp_dat_o; end
    exp_dat_i[3] = 1'b0;
    repeat (10) begin @(negedge clk); seen |= rise_o | fall_o | exp_dat_o; end
    chk("glitch_quiet", {24'd0, seen}, 0);
    rd("glitch_rise_f", 32'h04, 0);
    rd("glitch_fall_f", 32'h08, 0);
    exp_dat_i[0] = 1'b1;
    cyc(5);
    chk("rise_early", {24'd0, exp_dat_o}, 0);
    cyc(1);
    chk("rise_dat", {24'd0, exp_dat_o}, 32'h01);
    chk("rise_pulse", {24'd0, rise_o}, 32'h01);
    cyc(1);
    chk("rise_pulse_end", {24'd0, rise_o}, 0);
    rd("rise_f", 32'h04, 32'h01);
    rd("state", 32'h00, 32'h01);
    exp_dat_i[0] = 1'b0;
    cyc(8);
    chk("fall_dat", {24'd0, exp_dat_o}, 0);
    rd("fall_f", 32'h08, 32'h01);
    exp_dat_i[0] = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 20 && !ok; i++) begin @(negedge clk); ok = rise_o[0]; end
    chk("rise2_seen", {31'd0, ok}, 1);
    sys_addr = 32'h04; sys_wdata = 32'h01; sys_wen = 1'b1;
    @(negedge clk);
    sys_wen = 1'b0;
    rd("set_wins", 32'h04, 32'h01);
    wr(32'h04, 32'h01);
    rd("w1c_clear", 32'h04, 0);
    rd("fall_f_kept", 32'h08, 32'h01);
    wr(32'h0C, 32'd0);
    rd("deb_0", 32'h0C, 0);
    exp_dat_i[5] = 1'b1;
    cyc(2);
    chk("n1_early", {24'd0, exp_dat_o}, 32'h01);
    cyc(1);
    chk("n1_dat", {24'd0, exp_dat_o}, 32'h21);
    rd("unmapped", 32'h2C, 0);
    chk("unmapped_err", {31'd0, sys_err}, 0);
    cyc(1);
    chk("ack_single", {31'd0, sys_ack}, 0);
    wr(32'h2C, 32'hFFFF);
    rd("unmapped_wr", 32'h0C, 0);
    rd("irqmask_rd", 32'h10, 0);
    wr(32'h0C, 32'd100);
    exp_dat_i[1] = 1'b1;
    cyc(10);
    #2 rstn_i = 1'b0;
    #1;
    chk("arst_dat", {24'd0, exp_dat_o}, 0);
    chk("arst_edges", {16'd0, rise_o, fall_o}, 0);
    chk("arst_rdata", sys_rdata, 0);
    chk("arst_ack", {31'd0, sys_ack}, 0);
    cyc(2);
    rstn_i = 1'b1;
    rd("arst_deb", 32'h0C, 32'd1250);
`ifdef EXP_DEB_IRQ_EN
    wr(32'h0C, 32'd1);
    exp_dat_i = 8'h04;
    cyc(6);
    wr(32'h04, 32'hFF);
    wr(32'h08, 32'hFF);
    wr(32'h10, 32'h04);
    rd("mask_rd", 32'h10, 32'h04);
    chk("irq_idle", {31'd0, irq_o}, 0);
    exp_dat_i = 8'h00;
    ok = 1'b0;
    for (int i = 0; i < 20 && !ok; i++) begin @(negedge clk); ok = fall_o[2]; end
    chk("fall2_seen", {31'd0, ok}, 1);
    chk("irq_pre", {31'd0, irq_o}, 0);
    cyc(1);
    chk("irq_flag_cyc", {31'd0, irq_o}, 0);
    cyc(1);
    chk("irq_set", {31'd0, irq_o}, 1);
    wr(32'h08, 32'h04);
    cyc(1);
    chk("irq_clr", {31'd0, irq_o}, 0);
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
